// File: rtl/kgp_pc_pkg.sv
// Shared constants and next-pc source encoding for the KGP-RISC fetch-stage PC unit.
// The source enum is also what the debug trace reports.
package kgp_pc_pkg;

    localparam int DEF_PC_WIDTH  = 32;
    localparam int DEF_RAS_DEPTH = 8;
    localparam int DEF_RESET_PC  = 0;
    localparam int DEF_SHORT_INC = 1;
    localparam int DEF_LONG_INC  = 2;

    typedef enum logic [1:0] {
        SRC_SEQ      = 2'd0,
        SRC_REDIRECT = 2'd1,
        SRC_RAS      = 2'd2
    } pc_src_e;

    // A valid return outranks a taken redirect, which outranks sequential flow.
    function automatic pc_src_e pick_src(input logic ras_hit, input logic redirect);
        pc_src_e src;
        if (ras_hit)
            src = SRC_RAS;
        else if (redirect)
            src = SRC_REDIRECT;
        else
            src = SRC_SEQ;
        return src;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decode/execute (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int PC_WIDTH  = 32,
    parameter int RAS_DEPTH = 8
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic                stall;
    logic                instr_valid;
    logic                instr_long;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                call;
    logic                ret;
    logic [PC_WIDTH-1:0] pc;
    logic [CNT_W-1:0]    ras_count;
    logic                ras_overflow;
    logic                ras_underflow;

    modport master (
        output stall, instr_valid, instr_long, redirect_valid, redirect_target, call, ret,
        input  pc, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, instr_valid, instr_long, redirect_valid, redirect_target, call, ret,
        output pc, ras_count, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack with sticky overflow/underflow flags.
// push & pop together is a swap: the top entry is replaced, or a plain push when empty.
module return_address_stack #(
    parameter int RAS_DEPTH = 8,
    parameter int PC_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [PC_WIDTH-1:0]              push_data,
    output logic [PC_WIDTH-1:0]              top_data,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]    top;
    logic                empty;
    logic                full;
    logic                swap;
    logic                wr_en;
    logic [PTR_W-1:0]    wr_addr;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign swap     = push & pop & ~empty;
    assign top_data = mem[top];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = top;
        if (!rst && push) begin
            wr_en   = 1'b1;
            wr_addr = swap ? top : top + PTR_W'(1);
        end
    end

    // Storage carries no reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (swap) begin
            top   <= top;
            count <= count;
        end else if (push) begin
            top <= top + PTR_W'(1);
            if (full)
                overflow <= 1'b1;
            else
                count <= count + CNT_W'(1);
            if (pop)
                underflow <= 1'b1;
        end else if (pop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                top   <= top - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter for the KGP-RISC fetch stage: sequential advance,
// redirects, and call/return through the return-address stack.
module pc_sequencer
    import kgp_pc_pkg::*;
#(
    parameter int                  PC_WIDTH  = DEF_PC_WIDTH,
    parameter int                  RAS_DEPTH = DEF_RAS_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(DEF_RESET_PC),
    parameter int                  SHORT_INC = DEF_SHORT_INC,
    parameter int                  LONG_INC  = DEF_LONG_INC
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] seq;
    logic [PC_WIDTH-1:0] ras_top;
    logic [CNT_W-1:0]    ras_cnt;
    logic                ras_ovf;
    logic                ras_unf;
    logic                advance;
    logic                push;
    logic                pop;
    pc_src_e             src;

    assign advance = bus.instr_valid & ~bus.stall;
    assign seq     = pc_q + (bus.instr_long ? PC_WIDTH'(LONG_INC) : PC_WIDTH'(SHORT_INC));

    // A call with no redirect is a protocol error and is not pushed, unless it is
    // paired with a return (swap), where the return supplies the destination.
    assign push = advance & bus.call & (bus.redirect_valid | bus.ret);
    assign pop  = advance & bus.ret;
    assign src  = pick_src(bus.ret && (ras_cnt != '0), bus.redirect_valid);

    always_comb begin
        pc_next = seq;
        case (src)
            SRC_RAS:      pc_next = ras_top;
            SRC_REDIRECT: pc_next = bus.redirect_target;
            default:      pc_next = seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else if (advance)
            pc_q <= pc_next;
    end

    return_address_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_WIDTH  (PC_WIDTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq),
        .top_data  (ras_top),
        .count     (ras_cnt),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    assign bus.pc            = pc_q;
    assign bus.ras_count     = ras_cnt;
    assign bus.ras_overflow  = ras_ovf;
    assign bus.ras_underflow = ras_unf;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the KGP-RISC fetch stage.
- Each accepted instruction advances the PC by a short or long increment, or redirects it to a branch/jump target.
- Call/return uses an internal circular return-address stack (RAS) of parametrised depth.
- Feeds instruction-memory address; takes redirect, stall and call/return controls from decode/execute.

Parameters:
- PC_WIDTH, 32, width of PC and targets.
- RAS_DEPTH, 8, number of return-address entries (power of 2, >=2).
- RESET_PC, 0, PC value loaded on reset.
- SHORT_INC, 1, PC increment for a short (1-word) instruction.
- LONG_INC, 2, PC increment for a long (2-word) instruction.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold all state this cycle.
- instr_valid  in  1  instruction at current pc is present; state may advance.
- instr_long  in  1  current instruction is long (selects LONG_INC).
- redirect_valid  in  1  branch/jump taken; load redirect_target.
- redirect_target  in  PC_WIDTH  taken-branch/jump destination.
- call  in  1  instruction is a call; push return address (requires redirect_valid).
- ret  in  1  instruction is a return; pop RAS into pc.
- pc  out  PC_WIDTH  current program counter (registered).
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries, 0..RAS_DEPTH.
- ras_overflow  out  1  sticky: a push was made while full.
- ras_underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset: pc=RESET_PC, ras_count=0, top pointer=0, ras_overflow=0, ras_underflow=0. RAS storage contents are don't-care.
- rst has priority over every other input.
- advance = instr_valid & ~stall. When advance=0, all registers hold.
- seq = pc + (instr_long ? LONG_INC : SHORT_INC), computed modulo 2^PC_WIDTH. 2^PC_WIDTH-1 plus 1 wraps to 0.
- Next-pc priority when advance=1:
  - (1) ret with ras_count>0: pc <= top entry.
  - (2) redirect_valid: pc <= redirect_target.
  - (3) otherwise pc <= seq.
- Push (call & redirect_valid & ~ret):
  - Write seq at top+1; top++; ras_count = min(count+1, RAS_DEPTH).
  - If already full, the oldest entry is overwritten (circular buffer) and ras_overflow is set to 1.
- Call without redirect_valid: protocol error. Treated as a plain instruction with no push.
- Pop (ret & ~call):
  - Non-empty: pc <= top entry; top--; count--.
  - Empty: ras_underflow is set to 1, no pointer change, and pc follows priorities (2)/(3).
- Simultaneous call & ret (swap):
  - Non-empty: pc <= top entry; that entry is overwritten with seq; count and top are unchanged.
  - Empty: ras_underflow is set to 1, push of seq as normal, and pc <= redirect_target if redirect_valid, else seq.
- Latency: one cycle. Inputs sampled at edge N determine pc after edge N; pc is never combinationally dependent on inputs.
- Sticky flags clear only on rst.
- Top-pointer arithmetic is modulo RAS_DEPTH.

Decomposition:
- Shared package kgp_pc_pkg holds:
  - default PC_WIDTH, RESET_PC, SHORT_INC, LONG_INC constants;
  - a next-pc source enum (SRC_SEQ, SRC_REDIRECT, SRC_RAS) used by pc_sequencer and the debug trace.
- One sub-module, return_address_stack:
  - Parameters RAS_DEPTH, PC_WIDTH.
  - Ports clk, rst, push, pop, push_data, top_data, count, overflow, underflow.
  - Implements the circular storage, pointers and sticky flags, including the swap case.
- pc_sequencer owns the pc register and the priority mux.

Test Plan:
- Reset and sequential advance: rst high 2 cycles, then instr_valid=1 with instr_long pattern 0,1,0 -> pc sequence 0,1,3,4. A stall cycle mid-sequence holds pc; instr_valid=0 holds pc.
- Redirect wins over increment: at pc=0x10, redirect_valid=1, target=0x80 -> pc=0x80 next cycle. With stall=1 the same cycle, pc stays 0x10.
- Call/return round trip: at pc=0x20, long call to 0x100 -> pc=0x100, ras_count=1. At 0x100, ret -> pc=0x22, ras_count=0.
- RAS overflow (RAS_DEPTH=4): 5 nested calls from pcs 0x0..0x4, all short -> ras_count=4, ras_overflow=1. Four rets -> return addresses 0x5,0x4,0x3,0x2. Fifth ret -> ras_underflow=1 and pc=seq.
- Swap and wrap: with RAS holding 0x40, call+ret at pc=0x30 with target 0x90 -> pc=0x40, top=0x31, count unchanged. With PC_WIDTH=8 at pc=0xFF, short instruction -> pc=0x00.
- Reset mid-operation: rst asserted with ras_count=3, redirect_valid=1 and stall=1 -> next cycle pc=RESET_PC, ras_count=0, both flags 0.
